// File: rtl/tf_biquad_mux_if.sv
// Sample, result and coefficient-load signals of the multiplexed biquad engine.
interface tf_biquad_mux_if #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 18,
  parameter int unsigned COEF_W = 18
) ();
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                     in_valid;
  logic                     in_ready;
  logic [CH_W-1:0]          in_ch;
  logic signed [DATA_W-1:0] in_data;

  logic                     out_valid;
  logic [CH_W-1:0]          out_ch;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_sat;

  logic                     coef_we;
  logic [CH_W-1:0]          coef_ch;
  logic [2:0]               coef_sel;
  logic signed [COEF_W-1:0] coef_data;

  logic                     clear;

  modport master (
    output in_valid, in_ch, in_data, coef_we, coef_ch, coef_sel, coef_data, clear,
    input  in_ready, out_valid, out_ch, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_ch, in_data, coef_we, coef_ch, coef_sel, coef_data, clear,
    output in_ready, out_valid, out_ch, out_data, out_sat
  );
endinterface

// File: rtl/tf_biquad_mux.sv
// Time-multiplexed direct-form-I biquad: one shared multiplier serves N_CH channels,
// each with its own coefficient set and x/y history. One sample per 7 cycles.
module tf_biquad_mux #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DATA_W    = 18,
  parameter int unsigned COEF_W    = 18,
  parameter int unsigned COEF_FRAC = 14,
  parameter int unsigned ACC_W     = 48
) (
  input logic            clk,
  input logic            rst,
  tf_biquad_mux_if.slave bus
);
  localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned PROD_W = DATA_W + COEF_W;

  localparam logic [CH_W:0]              NumCh    = (CH_W + 1)'(N_CH);
  localparam logic signed [COEF_W-1:0]   CoefOne  = COEF_W'(1) << COEF_FRAC;
  localparam logic signed [ACC_W-1:0]    RndHalf  = ACC_W'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_W-1:0]    DataMax  =
    {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0]    DataMin  =
    {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  if (ACC_W < DATA_W + COEF_W + 3) begin : g_acc_w_check
    $error("tf_biquad_mux: ACC_W must be at least DATA_W+COEF_W+3");
  end

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e                   state_q;
  logic [2:0]               cnt_q;
  logic                     in_ready_q;
  logic [CH_W-1:0]          ch_q;
  logic signed [DATA_W-1:0] x_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [COEF_W-1:0] shadow_q [5];

  // Coefficient bank, order b0 b1 b2 a1 a2
  logic signed [COEF_W-1:0] coef_q [N_CH][5];

  logic signed [DATA_W-1:0] x1_q [N_CH];
  logic signed [DATA_W-1:0] x2_q [N_CH];
  logic signed [DATA_W-1:0] y1_q [N_CH];
  logic signed [DATA_W-1:0] y2_q [N_CH];

  logic                     out_valid_q;
  logic [CH_W-1:0]          out_ch_q;
  logic signed [DATA_W-1:0] out_data_q;
  logic                     out_sat_q;

  logic                     accept;
  logic                     in_ch_ok;
  logic                     coef_ok;
  logic signed [COEF_W-1:0] mul_c;
  logic signed [DATA_W-1:0] mul_d;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  scaled;
  logic signed [DATA_W-1:0] y_d;
  logic                     sat_d;

  // A clear in the same cycle blocks acceptance
  assign bus.in_ready  = in_ready_q & ~bus.clear;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

  assign accept   = bus.in_valid & bus.in_ready;
  assign in_ch_ok = {1'b0, bus.in_ch} < NumCh;
  assign coef_ok  = bus.coef_we && ({1'b0, bus.coef_ch} < NumCh) && (bus.coef_sel < 3'd5);

  // Operand select, single MAC step, then round half-up and saturate the final sum
  always_comb begin
    mul_c = shadow_q[0];
    mul_d = x_q;
    unique case (cnt_q)
      3'd0: begin mul_c = shadow_q[0]; mul_d = x_q;        end
      3'd1: begin mul_c = shadow_q[1]; mul_d = x1_q[ch_q]; end
      3'd2: begin mul_c = shadow_q[2]; mul_d = x2_q[ch_q]; end
      3'd3: begin mul_c = shadow_q[3]; mul_d = y1_q[ch_q]; end
      default: begin mul_c = shadow_q[4]; mul_d = y2_q[ch_q]; end
    endcase
    prod     = mul_c * mul_d;
    prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    // Feedback (a) terms are subtracted
    acc_d    = (cnt_q >= 3'd3) ? acc_q - prod_ext : acc_q + prod_ext;
    scaled   = (acc_d + RndHalf) >>> COEF_FRAC;
    sat_d    = 1'b0;
    if (scaled > DataMax) begin
      y_d   = DataMax[DATA_W-1:0];
      sat_d = 1'b1;
    end else if (scaled < DataMin) begin
      y_d   = DataMin[DATA_W-1:0];
      sat_d = 1'b1;
    end else begin
      y_d   = scaled[DATA_W-1:0];
    end
  end

  // Coefficient bank: writes land immediately in any state; reset gives passthrough
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < int'(N_CH); c++) begin
        for (int k = 0; k < 5; k++) begin
          coef_q[c][k] <= (k == 0) ? CoefOne : '0;
        end
      end
    end else if (coef_ok) begin
      coef_q[bus.coef_ch][bus.coef_sel] <= bus.coef_data;
    end
  end

  // Engine FSM with registered outputs and per-channel history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      ch_q        <= '0;
      x_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      for (int k = 0; k < 5; k++) shadow_q[k] <= '0;
      for (int c = 0; c < int'(N_CH); c++) begin
        x1_q[c] <= '0;
        x2_q[c] <= '0;
        y1_q[c] <= '0;
        y2_q[c] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      if (bus.clear) begin
        // Abort any in-flight sample; coefficients are kept
        state_q    <= StIdle;
        in_ready_q <= 1'b1;
        cnt_q      <= '0;
        for (int c = 0; c < int'(N_CH); c++) begin
          x1_q[c] <= '0;
          x2_q[c] <= '0;
          y1_q[c] <= '0;
          y2_q[c] <= '0;
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            // Samples for nonexistent channels are consumed and dropped here
            if (accept && in_ch_ok) begin
              ch_q       <= bus.in_ch;
              x_q        <= bus.in_data;
              shadow_q   <= coef_q[bus.in_ch];
              acc_q      <= '0;
              cnt_q      <= '0;
              in_ready_q <= 1'b0;
              state_q    <= StMac;
            end
          end
          StMac: begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd4) begin
              out_data_q   <= y_d;
              out_ch_q     <= ch_q;
              out_sat_q    <= sat_d;
              out_valid_q  <= 1'b1;
              x2_q[ch_q]   <= x1_q[ch_q];
              x1_q[ch_q]   <= x_q;
              y2_q[ch_q]   <= y1_q[ch_q];
              y1_q[ch_q]   <= y_d;
              state_q      <= StOut;
            end
          end
          StOut: begin
            state_q    <= StIdle;
            in_ready_q <= 1'b1;
          end
          default: begin
            state_q    <= StIdle;
            in_ready_q <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tf_biquad_mux.sv
// Directed bench for tf_biquad_mux: an arithmetic reference model predicts every result,
// a negedge compare process checks data/channel/saturation/latency, and literal expectations
// pin the model on the hand-computed scenarios.
module tb_tf_biquad_mux;
  localparam int N_CH   = 3;
  localparam int CH_W   = 2;
  localparam int DATA_W = 18;
  localparam int COEF_W = 18;
  localparam int FRAC   = 14;
  localparam longint MAXV = 131071;
  localparam longint MINV = -131072;

  typedef struct {
    int     ch;
    longint data;
    bit     sat;
    int     cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int n_checks = 0;
  int n_errors = 0;
  int out_cnt  = 0;
  int seen_cnt = 0;
  longint last_data;
  int     last_ch;
  bit     last_sat;

  exp_t   exp_q[$];
  exp_t   cmp_e;
  longint m_coef [N_CH][5];
  longint m_x1 [N_CH];
  longint m_x2 [N_CH];
  longint m_y1 [N_CH];
  longint m_y2 [N_CH];

  tf_biquad_mux_if #(.N_CH(N_CH), .DATA_W(DATA_W), .COEF_W(COEF_W)) bus ();

  tf_biquad_mux #(
    .N_CH(N_CH), .DATA_W(DATA_W), .COEF_W(COEF_W), .COEF_FRAC(FRAC), .ACC_W(48)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < N_CH; c++) begin
      m_x1[c] = 0; m_x2[c] = 0; m_y1[c] = 0; m_y2[c] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      for (int k = 0; k < 5; k++) m_coef[c][k] = (k == 0) ? (longint'(1) << FRAC) : 0;
    end
    model_clear();
  endtask

  // y = round_half_up(sum / 2^FRAC), clamped to the output range
  task automatic model_accept(input int ch, input longint x);
    longint s, y;
    bit     sat;
    if (ch >= N_CH) return;
    s = m_coef[ch][0] * x + m_coef[ch][1] * m_x1[ch] + m_coef[ch][2] * m_x2[ch]
        - m_coef[ch][3] * m_y1[ch] - m_coef[ch][4] * m_y2[ch];
    y = (s + (longint'(1) << (FRAC - 1))) >>> FRAC;
    sat = 1'b0;
    if (y > MAXV) begin y = MAXV; sat = 1'b1; end
    if (y < MINV) begin y = MINV; sat = 1'b1; end
    exp_q.push_back('{ch, y, sat, cyc + 6});
    m_x2[ch] = m_x1[ch]; m_x1[ch] = x;
    m_y2[ch] = m_y1[ch]; m_y1[ch] = y;
  endtask

  // Every-cycle compare of the result strobe against the model queue
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) begin
        out_cnt++;
        last_data = longint'(bus.out_data);
        last_ch   = int'(bus.out_ch);
        last_sat  = bus.out_sat;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_out_valid: got out_valid=1 data %0d, expected no result",
                   bus.out_data);
        end else begin
          cmp_e = exp_q.pop_front();
          chk("cmp_ch", longint'(bus.out_ch), cmp_e.ch);
          chk("cmp_data", longint'(bus.out_data), cmp_e.data);
          chk("cmp_sat", longint'(bus.out_sat), cmp_e.sat);
          chk("cmp_latency_cycle", cyc, cmp_e.cyc);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL missing_out_valid: got none at cycle %0d, expected result %0d",
                 cyc, exp_q[0].data);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input int ch, input longint x);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_ch    = CH_W'(ch);
    bus.in_data  = DATA_W'(x);
    #1;
    while (!bus.in_ready && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      chk("send_timeout_in_ready", 0, 1);
    end else begin
      model_accept(ch, x);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input int ch, input longint d, input bit s);
    int n = 0;
    while (out_cnt == seen_cnt && n < 30) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (out_cnt == seen_cnt) begin
      chk({name, "_timeout"}, 0, 1);
    end else begin
      seen_cnt = out_cnt;
      chk({name, "_data"}, last_data, d);
      chk({name, "_ch"}, last_ch, ch);
      chk({name, "_sat"}, longint'(last_sat), longint'(s));
    end
  endtask

  task automatic wr_coef(input int ch, input int sel, input longint val);
    @(negedge clk);
    bus.coef_we   = 1'b1;
    bus.coef_ch   = CH_W'(ch);
    bus.coef_sel  = 3'(sel);
    bus.coef_data = COEF_W'(val);
    if (ch < N_CH && sel < 5) m_coef[ch][sel] = val;
    @(negedge clk);
    bus.coef_we = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    model_clear();
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_in_ready"}, longint'(bus.in_ready), 1);
    chk({name, "_out_valid"}, longint'(bus.out_valid), 0);
    chk({name, "_out_data"}, longint'(bus.out_data), 0);
    chk({name, "_out_ch"}, longint'(bus.out_ch), 0);
    chk({name, "_out_sat"}, longint'(bus.out_sat), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int accepts;
    bus.in_valid = 1'b0; bus.in_ch = '0; bus.in_data = '0;
    bus.coef_we = 1'b0; bus.coef_ch = '0; bus.coef_sel = '0; bus.coef_data = '0;
    bus.clear = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_outputs("reset");

    // Passthrough after reset, latency and busy window
    send(0, 1000);
    for (int i = 1; i <= 6; i++) begin
      chk("busy_in_ready", longint'(bus.in_ready), 0);
      @(posedge clk);
      #1;
    end
    chk("ready_at_t7", longint'(bus.in_ready), 1);
    expect_out("pass", 0, 1000, 1'b0);

    // Single-pole lowpass on ch0
    do_clear();
    wr_coef(0, 0, 4096);
    wr_coef(0, 3, -12288);
    send(0, 8192); expect_out("lp0_s0", 0, 2048, 1'b0);
    send(0, 8192); expect_out("lp0_s1", 0, 3584, 1'b0);
    send(0, 8192); expect_out("lp0_s2", 0, 4736, 1'b0);

    // Interleaved channels keep independent history
    wr_coef(1, 0, 4096);
    wr_coef(1, 3, -12288);
    send(1, 8192); expect_out("il_c1_s0", 1, 2048, 1'b0);
    send(2, 500);  expect_out("il_c2_s0", 2, 500, 1'b0);
    send(1, 8192); expect_out("il_c1_s1", 1, 3584, 1'b0);
    send(2, 500);  expect_out("il_c2_s1", 2, 500, 1'b0);
    send(1, 8192); expect_out("il_c1_s2", 1, 4736, 1'b0);
    send(2, 500);  expect_out("il_c2_s2", 2, 500, 1'b0);

    // Saturation and half-up rounding
    do_clear();
    wr_coef(0, 3, 0);
    wr_coef(0, 0, 32768);
    send(0, 100000);  expect_out("sat_pos", 0, 131071, 1'b1);
    send(0, -100000); expect_out("sat_neg", 0, -131072, 1'b1);
    wr_coef(0, 0, 8192);
    send(0, 3);  expect_out("rnd_pos", 0, 2, 1'b0);
    send(0, -3); expect_out("rnd_neg", 0, -1, 1'b0);

    // Ignored coefficient writes: bad select and bad channel
    wr_coef(0, 5, 1);
    wr_coef(3, 0, 1);
    send(0, 4); expect_out("bad_wr", 0, 2, 1'b0);

    // Clear mid-flight discards the sample and zeroes history
    wr_coef(0, 0, 4096);
    wr_coef(0, 3, -12288);
    do_clear();
    send(0, 8192);
    @(negedge clk); @(negedge clk); @(negedge clk);
    bus.clear = 1'b1;
    model_clear();
    @(negedge clk);
    bus.clear = 1'b0;
    c0 = out_cnt;
    repeat (10) @(negedge clk);
    chk("clear_no_out", out_cnt - c0, 0);
    seen_cnt = out_cnt;
    send(0, 8192); expect_out("after_clear", 0, 2048, 1'b0);

    // Coefficient write during MAC affects only later samples
    send(0, 8192);
    wr_coef(0, 0, 16384);
    expect_out("shadow_coef", 0, 3584, 1'b0);

    // Held in_valid: one acceptance per 7 cycles
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_ch    = CH_W'(2);
    bus.in_data  = DATA_W'(700);
    accepts = 0;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (bus.in_ready) begin
        accepts++;
        model_accept(2, 700);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("held_accepts", accepts, 3);
    repeat (8) @(negedge clk);
    chk("held_outputs", out_cnt - seen_cnt, 3);
    seen_cnt = out_cnt;
    chk("held_last_data", last_data, 700);

    // Out-of-range channel: consumed, dropped, no history change
    send(3, 555);
    chk("bad_ch_ready", longint'(bus.in_ready), 1);
    c0 = out_cnt;
    repeat (10) @(negedge clk);
    chk("bad_ch_no_out", out_cnt - c0, 0);
    send(0, 0); expect_out("bad_ch_hist", 0, 2688, 1'b0);

    // Reset mid-MAC
    send(0, 5000);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    chk_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    seen_cnt = out_cnt;
    send(0, 1234); expect_out("post_rst", 0, 1234, 1'b0);

    repeat (10) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
